// File: rtl/snake_pkg.sv
// +----------------------------------------------------------------------------+
// | Package     : snake_pkg                                                    |
// | Description : Shared board geometry and cell helpers for the snake game.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package snake_pkg;

    localparam int CELL_W  = 6;
    localparam int H_CELLS = 40;
    localparam int V_CELLS = 30;

    function automatic logic cell_match(
        input logic [CELL_W-1:0] ax,
        input logic [CELL_W-1:0] ay,
        input logic [CELL_W-1:0] bx,
        input logic [CELL_W-1:0] by
    );
        return (ax == bx) && (ay == by);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------------+
// | Module      : sat_counter                                                  |
// | Description : Up-counter with synchronous clear that holds at MAX.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 999
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fruit_controller.sv
// +----------------------------------------------------------------------------+
// | Module      : fruit_controller                                             |
// | Description : Fruit lifecycle for the snake game: placement handshake,     |
// |               eat detection, grow pulse and saturating score.              |
// |               Optional macro FRUIT_RESPAWN_EN relocates an uneaten fruit   |
// |               after RESPAWN_TICKS non-eating move ticks.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fruit_controller
    import snake_pkg::*;
#(
    parameter int SCORE_MAX     = 999,
    parameter int RESPAWN_TICKS = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              game_start,
    input  logic              move_tick,
    input  logic [CELL_W-1:0] head_x_cell,
    input  logic [CELL_W-1:0] head_y_cell,
    output logic              place_req,
    input  logic              place_busy,
    input  logic              place_done,
    input  logic [CELL_W-1:0] place_x_cell,
    input  logic [CELL_W-1:0] place_y_cell,
    output logic [CELL_W-1:0] fruit_x_cell,
    output logic [CELL_W-1:0] fruit_y_cell,
    output logic              fruit_valid,
    output logic              grow,
    output logic [9:0]        score
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_ACTIVE = 2'd3;

    if (RESPAWN_TICKS < 1) begin : g_respawn_ticks_invalid
        $error("RESPAWN_TICKS must be at least 1");
    end

    logic [1:0]        r_state;
    logic              r_place_req;
    logic              r_grow;
    logic              r_fruit_valid;
    logic [CELL_W-1:0] r_fruit_x;
    logic [CELL_W-1:0] r_fruit_y;

    logic w_eat;
    logic w_timeout;
    logic w_score_inc;

    assign w_eat = (r_state == S_ACTIVE) && move_tick &&
                   cell_match(head_x_cell, head_y_cell, r_fruit_x, r_fruit_y);

    // A restart in the same cycle as an eat cancels the eat entirely.
    assign w_score_inc = w_eat && !game_start;

`ifdef FRUIT_RESPAWN_EN
    localparam int TIMER_W = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(RESPAWN_TICKS - 1);

    logic [TIMER_W-1:0] r_timer;
    logic               w_miss_tick;

    assign w_miss_tick = (r_state == S_ACTIVE) && move_tick && !w_eat;
    assign w_timeout   = w_miss_tick && (r_timer == C_TIMER_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (game_start || w_eat || w_timeout) begin
            r_timer <= '0;
        end else if ((r_state == S_WAIT) && place_done) begin
            r_timer <= '0;
        end else if (w_miss_tick) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_place_req   <= 1'b0;
            r_grow        <= 1'b0;
            r_fruit_valid <= 1'b0;
            r_fruit_x     <= '0;
            r_fruit_y     <= '0;
        end else begin
            r_place_req <= 1'b0;
            r_grow      <= 1'b0;
            if (game_start) begin
                r_state       <= S_REQ;
                r_fruit_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_REQ: begin
                        if (!place_busy) begin
                            r_place_req <= 1'b1;
                            r_state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (place_done) begin
                            r_fruit_x     <= place_x_cell;
                            r_fruit_y     <= place_y_cell;
                            r_fruit_valid <= 1'b1;
                            r_state       <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (w_eat) begin
                            r_grow        <= 1'b1;
                            r_fruit_valid <= 1'b0;
                            r_state       <= S_REQ;
                        end else if (w_timeout) begin
                            r_fruit_valid <= 1'b0;
                            r_state       <= S_REQ;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (10),
        .MAX   (SCORE_MAX)
    ) u_score (
        .clk    (clk),
        .resetn (resetn),
        .clear  (game_start),
        .inc    (w_score_inc),
        .count  (score)
    );

    assign place_req    = r_place_req;
    assign grow         = r_grow;
    assign fruit_valid  = r_fruit_valid;
    assign fruit_x_cell = r_fruit_x;
    assign fruit_y_cell = r_fruit_y;

endmodule

`default_nettype wire

// File: tb/tb_fruit_controller.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_fruit_controller                                          |
// | Description : Self-checking bench for fruit_controller with random         |
// |               placements and a score/fruit reference model.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fruit_controller;
    import snake_pkg::*;

    localparam int SCORE_MAX = 999;
`ifdef FRUIT_RESPAWN_EN
    localparam int RESPAWN_TICKS = 4;
`else
    localparam int RESPAWN_TICKS = 64;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              game_start = 1'b0;
    logic              move_tick = 1'b0;
    logic [CELL_W-1:0] head_x_cell = '0;
    logic [CELL_W-1:0] head_y_cell = '0;
    logic              place_req;
    logic              place_busy = 1'b0;
    logic              place_done = 1'b0;
    logic [CELL_W-1:0] place_x_cell = '0;
    logic [CELL_W-1:0] place_y_cell = '0;
    logic [CELL_W-1:0] fruit_x_cell;
    logic [CELL_W-1:0] fruit_y_cell;
    logic              fruit_valid;
    logic              grow;
    logic [9:0]        score;

    fruit_controller #(
        .SCORE_MAX     (SCORE_MAX),
        .RESPAWN_TICKS (RESPAWN_TICKS)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .game_start   (game_start),
        .move_tick    (move_tick),
        .head_x_cell  (head_x_cell),
        .head_y_cell  (head_y_cell),
        .place_req    (place_req),
        .place_busy   (place_busy),
        .place_done   (place_done),
        .place_x_cell (place_x_cell),
        .place_y_cell (place_y_cell),
        .fruit_x_cell (fruit_x_cell),
        .fruit_y_cell (fruit_y_cell),
        .fruit_valid  (fruit_valid),
        .grow         (grow),
        .score        (score)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: fruits eaten since the last start, and the last placed cell.
    int                exp_score = 0;
    logic [CELL_W-1:0] exp_fx = '0;
    logic [CELL_W-1:0] exp_fy = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int model_eat(input int s);
        return (s < SCORE_MAX) ? s + 1 : SCORE_MAX;
    endfunction

    task automatic pick_miss_head;
        head_x_cell = CELL_W'($urandom_range(0, H_CELLS - 1));
        head_y_cell = CELL_W'($urandom_range(0, V_CELLS - 1));
        if (head_x_cell == exp_fx && head_y_cell == exp_fy)
            head_x_cell = (head_x_cell == CELL_W'(H_CELLS - 1)) ? '0 : head_x_cell + 1'b1;
    endtask

    // Entered right after the edge that put the DUT into its request state.
    task automatic place_fruit(input logic [CELL_W-1:0] x, input logic [CELL_W-1:0] y,
                               input int busy_cycles);
        place_busy = 1'b1;
        for (int i = 0; i < busy_cycles; i++) begin
            tick;
            n_checks++;
            if (place_req !== 1'b0) begin
                n_fails++;
                $display("FAIL place_req_while_busy: got %b want 0", place_req);
            end
        end
        place_busy = 1'b0;
        tick;
        n_checks++;
        if (place_req !== 1'b1 || grow !== 1'b0) begin
            n_fails++;
            $display("FAIL place_req_pulse: got req=%b grow=%b want req=1 grow=0", place_req, grow);
        end
        place_done   = 1'b1;
        place_x_cell = x;
        place_y_cell = y;
        tick;
        place_done = 1'b0;
        exp_fx = x;
        exp_fy = y;
        n_checks++;
        if (place_req !== 1'b0 || fruit_valid !== 1'b1 ||
            fruit_x_cell !== exp_fx || fruit_y_cell !== exp_fy) begin
            n_fails++;
            $display("FAIL place_result: got req=%b valid=%b (%0d,%0d) want req=0 valid=1 (%0d,%0d)",
                     place_req, fruit_valid, fruit_x_cell, fruit_y_cell, exp_fx, exp_fy);
        end
    endtask

    task automatic random_place(input int max_busy);
        place_fruit(CELL_W'($urandom_range(0, H_CELLS - 1)),
                    CELL_W'($urandom_range(0, V_CELLS - 1)),
                    int'($urandom_range(0, max_busy)));
    endtask

    task automatic do_eat;
        head_x_cell = exp_fx;
        head_y_cell = exp_fy;
        move_tick = 1'b1;
        tick;
        move_tick = 1'b0;
        exp_score = model_eat(exp_score);
        n_checks++;
        if (grow !== 1'b1 || fruit_valid !== 1'b0 || score !== 10'(exp_score)) begin
            n_fails++;
            $display("FAIL eat: got grow=%b valid=%b score=%0d want grow=1 valid=0 score=%0d",
                     grow, fruit_valid, score, exp_score);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) tick;
        n_checks++;
        if (place_req !== 1'b0 || grow !== 1'b0 || fruit_valid !== 1'b0 ||
            fruit_x_cell !== '0 || fruit_y_cell !== '0 || score !== '0) begin
            n_fails++;
            $display("FAIL reset_state: got req=%b grow=%b valid=%b (%0d,%0d) score=%0d want all 0",
                     place_req, grow, fruit_valid, fruit_x_cell, fruit_y_cell, score);
        end
        resetn = 1'b1;
        // Idle must ignore everything except game_start.
        for (int i = 0; i < 6; i++) begin
            move_tick    = 1'($urandom_range(0, 1));
            place_done   = 1'($urandom_range(0, 1));
            place_x_cell = CELL_W'($urandom_range(1, 30));
            tick;
            n_checks++;
            if (place_req !== 1'b0 || fruit_valid !== 1'b0 || grow !== 1'b0) begin
                n_fails++;
                $display("FAIL idle_ignores: got req=%b valid=%b grow=%b want 0 0 0",
                         place_req, fruit_valid, grow);
            end
        end
        move_tick  = 1'b0;
        place_done = 1'b0;
    endtask

    task automatic test_first_fruit;
        game_start = 1'b1;
        tick;
        game_start = 1'b0;
        exp_score = 0;
        place_fruit(6'd10, 6'd5, 3);
        n_checks++;
        if (score !== 10'd0) begin
            n_fails++;
            $display("FAIL first_score: got %0d want 0", score);
        end
    endtask

    task automatic test_eat;
        for (int i = 0; i < 2; i++) begin
            head_x_cell = (i == 0) ? 6'd10 : 6'd11;
            head_y_cell = (i == 0) ? 6'd6 : 6'd5;
            move_tick = 1'b1;
            tick;
            move_tick = 1'b0;
            n_checks++;
            if (grow !== 1'b0 || fruit_valid !== 1'b1 || score !== 10'(exp_score)) begin
                n_fails++;
                $display("FAIL near_miss: got grow=%b valid=%b score=%0d want 0 1 %0d",
                         grow, fruit_valid, score, exp_score);
            end
        end
        do_eat;
        random_place(2);
    endtask

    task automatic test_random;
        int lim;
        lim = (RESPAWN_TICKS > 6) ? 5 : RESPAWN_TICKS - 2;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < int'($urandom_range(0, lim)); k++) begin
                pick_miss_head;
                move_tick = 1'b1;
                // A stray result strobe while active must not move the fruit.
                place_done   = 1'($urandom_range(0, 1));
                place_x_cell = CELL_W'($urandom_range(0, H_CELLS - 1));
                place_y_cell = CELL_W'($urandom_range(0, V_CELLS - 1));
                tick;
                move_tick  = 1'b0;
                place_done = 1'b0;
                n_checks++;
                if (grow !== 1'b0 || fruit_valid !== 1'b1 ||
                    fruit_x_cell !== exp_fx || fruit_y_cell !== exp_fy) begin
                    n_fails++;
                    $display("FAIL random_miss: got grow=%b valid=%b (%0d,%0d) want 0 1 (%0d,%0d)",
                             grow, fruit_valid, fruit_x_cell, fruit_y_cell, exp_fx, exp_fy);
                end
            end
            do_eat;
            random_place(3);
        end
    endtask

    task automatic test_ignored_ticks;
        logic [CELL_W-1:0] old_x, old_y;
        old_x = exp_fx;
        old_y = exp_fy;
        do_eat;
        head_x_cell = old_x;
        head_y_cell = old_y;
        place_busy = 1'b1;
        move_tick  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_checks++;
            if (grow !== 1'b0 || place_req !== 1'b0 || score !== 10'(exp_score)) begin
                n_fails++;
                $display("FAIL tick_in_req: got grow=%b req=%b score=%0d want 0 0 %0d",
                         grow, place_req, score, exp_score);
            end
        end
        place_busy = 1'b0;
        tick;
        tick;
        move_tick = 1'b0;
        n_checks++;
        if (grow !== 1'b0 || fruit_valid !== 1'b0 || score !== 10'(exp_score)) begin
            n_fails++;
            $display("FAIL tick_in_wait: got grow=%b valid=%b score=%0d want 0 0 %0d",
                     grow, fruit_valid, score, exp_score);
        end
        place_done   = 1'b1;
        place_x_cell = 6'd20;
        place_y_cell = 6'd7;
        tick;
        place_done = 1'b0;
        exp_fx = 6'd20;
        exp_fy = 6'd7;
        n_checks++;
        if (fruit_valid !== 1'b1 || fruit_x_cell !== exp_fx || fruit_y_cell !== exp_fy) begin
            n_fails++;
            $display("FAIL wait_result: got valid=%b (%0d,%0d) want 1 (%0d,%0d)",
                     fruit_valid, fruit_x_cell, fruit_y_cell, exp_fx, exp_fy);
        end
    endtask

    task automatic test_saturation;
        while (exp_score < SCORE_MAX) begin
            do_eat;
            random_place(0);
        end
        do_eat;
        n_checks++;
        if (score !== 10'd999) begin
            n_fails++;
            $display("FAIL score_saturate: got %0d want 999", score);
        end
        random_place(1);
    endtask

    task automatic test_eat_and_start;
        head_x_cell = exp_fx;
        head_y_cell = exp_fy;
        move_tick  = 1'b1;
        game_start = 1'b1;
        tick;
        move_tick  = 1'b0;
        game_start = 1'b0;
        exp_score = 0;
        n_checks++;
        if (grow !== 1'b0 || score !== 10'd0 || fruit_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL eat_vs_start: got grow=%b score=%0d valid=%b want 0 0 0",
                     grow, score, fruit_valid);
        end
        random_place(0);
    endtask

    task automatic test_respawn;
`ifdef FRUIT_RESPAWN_EN
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 1; k <= RESPAWN_TICKS; k++) begin
                pick_miss_head;
                move_tick = 1'b1;
                tick;
                move_tick = 1'b0;
                n_checks++;
                if (fruit_valid !== ((k < RESPAWN_TICKS) ? 1'b1 : 1'b0) ||
                    grow !== 1'b0 || score !== 10'(exp_score)) begin
                    n_fails++;
                    $display("FAIL respawn_tick%0d: got valid=%b grow=%b score=%0d want %b 0 %0d",
                             k, fruit_valid, grow, score, (k < RESPAWN_TICKS), exp_score);
                end
            end
            random_place(1);
        end
        // Eat on the would-be final tick counts as an eat.
        for (int k = 1; k < RESPAWN_TICKS; k++) begin
            pick_miss_head;
            move_tick = 1'b1;
            tick;
            move_tick = 1'b0;
        end
        do_eat;
        random_place(0);
`else
        for (int k = 0; k < RESPAWN_TICKS + 6; k++) begin
            pick_miss_head;
            move_tick = 1'b1;
            tick;
            move_tick = 1'b0;
        end
        n_checks++;
        if (fruit_valid !== 1'b1 || fruit_x_cell !== exp_fx || fruit_y_cell !== exp_fy ||
            grow !== 1'b0 || score !== 10'(exp_score)) begin
            n_fails++;
            $display("FAIL no_respawn: got valid=%b (%0d,%0d) score=%0d want 1 (%0d,%0d) %0d",
                     fruit_valid, fruit_x_cell, fruit_y_cell, score, exp_fx, exp_fy, exp_score);
        end
`endif
    endtask

    task automatic test_reset_wait;
        do_eat;
        place_busy = 1'b0;
        tick;
        n_checks++;
        if (place_req !== 1'b1) begin
            n_fails++;
            $display("FAIL req_before_reset: got %b want 1", place_req);
        end
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        exp_score = 0;
        place_done   = 1'b1;
        place_x_cell = 6'd33;
        place_y_cell = 6'd22;
        tick;
        place_done = 1'b0;
        n_checks++;
        if (fruit_valid !== 1'b0 || fruit_x_cell !== '0 || fruit_y_cell !== '0 || score !== '0) begin
            n_fails++;
            $display("FAIL reset_in_wait: got valid=%b (%0d,%0d) score=%0d want 0 (0,0) 0",
                     fruit_valid, fruit_x_cell, fruit_y_cell, score);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (place_req !== 1'b0 || fruit_valid !== 1'b0) begin
                n_fails++;
                $display("FAIL idle_after_reset: got req=%b valid=%b want 0 0", place_req, fruit_valid);
            end
        end
        game_start = 1'b1;
        tick;
        game_start = 1'b0;
        place_fruit(6'd39, 6'd29, 1);
    endtask

    initial begin
        test_reset;
        test_first_fruit;
        test_eat;
        test_random;
        test_ignored_ticks;
        test_respawn;
        test_saturation;
        test_eat_and_start;
        test_reset_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/fruit_controller.md
FRUIT_CONTROLLER -- requirements
Module: fruit_controller

Interface
REQ-001 SHALL have parameter SCORE_MAX, default 999; saturation limit of score.
REQ-002 SHALL have parameter RESPAWN_TICKS, default 64; number of move ticks before an uneaten fruit relocates.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port game_start  input  1  one-cycle pulse; starts a new round.
REQ-006 SHALL have port move_tick  input  1  one-cycle pulse; head position is valid this cycle.
REQ-007 SHALL have ports head_x_cell / head_y_cell  input  6 each  snake head cell coordinates.
REQ-008 SHALL have port place_req  output  1  one-cycle request pulse to the placer.
REQ-009 SHALL have ports place_busy / place_done  input  1 each  placer status; place_done is a one-cycle result strobe.
REQ-010 SHALL have ports place_x_cell / place_y_cell  input  6 each  placer result, valid when place_done=1.
REQ-011 SHALL have ports fruit_x_cell / fruit_y_cell  output  6 each  current fruit cell.
REQ-012 SHALL have port fruit_valid  output  1  a fruit is on the board.
REQ-013 SHALL have port grow  output  1  one-cycle pulse; the snake grows by one segment.
REQ-014 SHALL have port score  output  10  fruits eaten, saturating.

Function
REQ-015 SHALL implement the FSM states S_IDLE, S_REQ, S_WAIT and S_ACTIVE.
REQ-016 SHALL, from S_IDLE, go to S_REQ on game_start; all other inputs are ignored in S_IDLE.
REQ-017 SHALL, in S_REQ, hold while place_busy=1; when place_busy=0, set place_req=1 for exactly one cycle and go to S_WAIT.
REQ-018 SHALL, in S_WAIT, latch place_x/y_cell into fruit_x/y_cell on place_done, set fruit_valid=1, clear the timer and go to S_ACTIVE.
REQ-019 SHALL, in S_ACTIVE, detect an eat when move_tick=1 and the head equals the fruit (both coordinates).
REQ-020 SHALL, on an eat, at the next edge: grow=1 for one cycle, score+1 saturating at SCORE_MAX, fruit_valid=0, go to S_REQ; latency from the sampled move_tick to grow is one cycle.
REQ-021 SHALL ignore move_tick in S_REQ and S_WAIT (no fruit means no eat).
REQ-022 SHALL, on game_start in any state, clear score, fruit_valid and the timer, and go to S_REQ; game_start wins over a simultaneous eat (no grow, score=0).
REQ-023 SHALL ignore place_done outside S_WAIT.
REQ-024 SHALL register all outputs; grow and place_req are never high for two consecutive cycles.

Reset
REQ-025 SHALL, while resetn=0, force: state=S_IDLE, place_req=0, grow=0, fruit_valid=0, fruit_x/y_cell=0, score=0, timer=0.
REQ-026 SHALL, on reset mid-S_WAIT, discard the placer result and require a new game_start.

Configuration
REQ-027 SHALL, with FRUIT_RESPAWN_EN defined, count move_ticks in S_ACTIVE that are not eats.
REQ-028 SHALL, when that count reaches RESPAWN_TICKS: set fruit_valid=0, go to S_REQ, no grow, score unchanged.
REQ-029 SHALL, when an eat and the final tick coincide, treat the event as an eat.
REQ-030 SHALL, without FRUIT_RESPAWN_EN, have no timer logic; the fruit stays until eaten.

Structure
REQ-031 SHALL take CELL_W=6, H_CELLS=40 and V_CELLS=30 from shared package snake_pkg; the FSM state encoding is local.
REQ-032 SHALL implement the score as one sub-module, sat_counter (clear, inc, saturate at MAX).

Verification
REQ-033 Scenario: game_start; placer busy 3 cycles, then done with (10,5) -> place_req one pulse after busy drops; fruit=(10,5); fruit_valid=1.
REQ-034 Scenario: fruit (10,5); move_tick with head (10,5) -> grow pulse next cycle; score 0->1; new place_req issued.
REQ-035 Scenario: score=999; eat -> score stays 999; grow still pulses.
REQ-036 Scenario: eat and game_start in the same cycle -> score=0; no grow; state S_REQ.
REQ-037 Scenario (FRUIT_RESPAWN_EN, RESPAWN_TICKS=4): 4 non-eat ticks -> fruit_valid=0; place_req; score unchanged; 64 ticks with macro off -> fruit unchanged.
REQ-038 Scenario: resetn low during S_WAIT, then place_done -> fruit_valid stays 0; state S_IDLE.
